// File: rtl/venus_core.sv
`default_nettype none
// ============================================================================
//  Module   : venus_core
//  Purpose  : Three-stage (IF / ID / EX) in-order 16-bit CPU core with an
//             internal instruction ROM, a 16 x 16-bit register file guarded
//             by a per-register write-reservation scoreboard, and a 4-bit
//             status register {N,Z,V,C}. No external data bus.
//  Ports    : clk  - single clock, rising edge
//             rst  - asynchronous, active-low reset (rst=0 resets)
//  Params   : IMEM_FILE - name of the ROM image (256 x 16-bit words)
//             IMEM_AW   - PC / ROM word-address width (<= 16)
//             IMEM_INIT - pre-converted contents of the image named by
//                         IMEM_FILE, word n at bits [16*n +: 16]
//  Config   : VENUS_MUL_EN - when defined, opcode B is an unsigned 16x16
//             multiply (low half, updates N/Z only); otherwise opcode B is
//             a NOP.
//  Revision : 1.0 - initial release
// ============================================================================
module venus_core #(
    parameter                               IMEM_FILE = "imem.hex",
    parameter int                           IMEM_AW   = 8,
    parameter logic [16*(1<<IMEM_AW)-1:0]   IMEM_INIT = '0
) (
    input  logic clk,
    input  logic rst
);

    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_ADDX = 4'h2;
    localparam logic [3:0] c_OP_SUB  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_XOR  = 4'h6;
    localparam logic [3:0] c_OP_MOV  = 4'h7;
    localparam logic [3:0] c_OP_LDI  = 4'h8;
    localparam logic [3:0] c_OP_LDIH = 4'h9;
    localparam logic [3:0] c_OP_BCC  = 4'hA;
`ifdef VENUS_MUL_EN
    localparam logic [3:0] c_OP_MUL  = 4'hB;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IMEM_AW-1:0] r_pc;
    logic               r_v_ifid;
    logic [15:0]        r_inst_memid;
    logic [IMEM_AW-1:0] r_origaddr;

    logic [15:0]        r_regs [16];
    logic [15:0]        r_reserve;
    logic [3:0]         r_status;      // {N,Z,V,C}

    logic               r_v_idex;
    logic [3:0]         r_ex_opc;
    logic [3:0]         r_ex_rd;       // destination or branch condition
    logic [15:0]        r_ex_a;        // rd operand
    logic [15:0]        r_ex_b;        // rs operand
    logic [7:0]         r_ex_imm8;
    logic [IMEM_AW-1:0] r_ex_addr;
    logic               r_ex_wr;

    // ------------------------------------------------------------------
    // Instruction ROM: a constant table. An empty image name builds a
    // ROM that returns NOP everywhere.
    // ------------------------------------------------------------------
    logic [15:0] w_rom_word;

    if (IMEM_FILE != "") begin : g_rom_image
        assign w_rom_word = IMEM_INIT[{r_pc, 4'b0000} +: 16];
    end else begin : g_rom_blank
        assign w_rom_word = 16'h0000;
    end

    // ------------------------------------------------------------------
    // ID: decode, operand read, hazard detection
    // ------------------------------------------------------------------
    logic [3:0] w_id_opc;
    logic [3:0] w_id_rd;
    logic [3:0] w_id_rs;
    logic       w_id_use_rd;
    logic       w_id_use_rs;
    logic       w_id_wr;
    logic       w_hazard;
    logic       w_stall_idif;
    logic       w_issue;
    logic       w_reserve;
    logic       w_branch;
    logic [IMEM_AW-1:0] w_baddr;

    assign w_id_opc = r_inst_memid[15:12];
    assign w_id_rd  = r_inst_memid[11:8];
    assign w_id_rs  = r_inst_memid[7:4];

    always_comb begin
        w_id_use_rd = 1'b0;
        w_id_use_rs = 1'b0;
        w_id_wr     = 1'b0;
        case (w_id_opc)
            c_OP_ADD, c_OP_ADDX, c_OP_SUB,
            c_OP_AND, c_OP_OR, c_OP_XOR: begin
                w_id_use_rd = 1'b1;
                w_id_use_rs = 1'b1;
                w_id_wr     = 1'b1;
            end
            c_OP_MOV: begin
                w_id_use_rs = 1'b1;
                w_id_wr     = 1'b1;
            end
            c_OP_LDI: begin
                w_id_wr     = 1'b1;
            end
            c_OP_LDIH: begin
                // LDIH keeps the low byte of rd, so rd is a source too.
                w_id_use_rd = 1'b1;
                w_id_wr     = 1'b1;
            end
`ifdef VENUS_MUL_EN
            c_OP_MUL: begin
                w_id_use_rd = 1'b1;
                w_id_use_rs = 1'b1;
                w_id_wr     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign w_hazard     = (w_id_use_rd & r_reserve[w_id_rd]) |
                          (w_id_use_rs & r_reserve[w_id_rs]);
    assign w_stall_idif = r_v_ifid & w_hazard;
    // An instruction in ID while a taken branch sits in EX is squashed
    // before it can reserve anything, so no reservation is left behind.
    assign w_issue      = r_v_ifid & ~w_hazard & ~w_branch;
    assign w_reserve    = w_issue & w_id_wr;

    // ------------------------------------------------------------------
    // EX: ALU, flags, branch resolution
    // ------------------------------------------------------------------
    logic [16:0] w_sum;
    logic [15:0] w_rd_data;
    logic [3:0]  w_flags_next;
    logic        w_cond_true;
`ifdef VENUS_MUL_EN
    logic [15:0] w_mul_lo;
    assign w_mul_lo = r_ex_a * r_ex_b;
`endif

    always_comb begin
        w_sum        = 17'd0;
        w_rd_data    = r_ex_a;
        w_flags_next = r_status;
        w_cond_true  = 1'b0;
        case (r_ex_opc)
            c_OP_ADD, c_OP_ADDX: begin
                w_sum = {1'b0, r_ex_a} + {1'b0, r_ex_b} +
                        {16'd0, (r_ex_opc == c_OP_ADDX) & r_status[0]};
                w_rd_data    = w_sum[15:0];
                w_flags_next = {w_sum[15], (w_sum[15:0] == 16'd0),
                                (r_ex_a[15] == r_ex_b[15]) && (w_sum[15] != r_ex_a[15]),
                                w_sum[16]};
            end
            c_OP_SUB: begin
                // Carry is "no borrow": set when rd >= rs unsigned.
                w_sum        = {1'b0, r_ex_a} - {1'b0, r_ex_b};
                w_rd_data    = w_sum[15:0];
                w_flags_next = {w_sum[15], (w_sum[15:0] == 16'd0),
                                (r_ex_a[15] != r_ex_b[15]) && (w_sum[15] != r_ex_a[15]),
                                ~w_sum[16]};
            end
            c_OP_AND, c_OP_OR, c_OP_XOR: begin
                if (r_ex_opc == c_OP_AND)
                    w_rd_data = r_ex_a & r_ex_b;
                else if (r_ex_opc == c_OP_OR)
                    w_rd_data = r_ex_a | r_ex_b;
                else
                    w_rd_data = r_ex_a ^ r_ex_b;
                w_flags_next = {w_rd_data[15], (w_rd_data == 16'd0), 1'b0, r_status[0]};
            end
            c_OP_MOV:  w_rd_data = r_ex_b;
            c_OP_LDI:  w_rd_data = {{8{r_ex_imm8[7]}}, r_ex_imm8};
            c_OP_LDIH: w_rd_data = {r_ex_imm8, r_ex_a[7:0]};
            c_OP_BCC: begin
                case (r_ex_rd)
                    4'd0:    w_cond_true = 1'b1;
                    4'd1:    w_cond_true = r_status[2];
                    4'd2:    w_cond_true = ~r_status[2];
                    4'd3:    w_cond_true = r_status[0];
                    4'd4:    w_cond_true = ~r_status[0];
                    4'd5:    w_cond_true = r_status[3];
                    4'd6:    w_cond_true = ~r_status[3];
                    default: w_cond_true = 1'b0;
                endcase
            end
`ifdef VENUS_MUL_EN
            c_OP_MUL: begin
                w_rd_data    = w_mul_lo;
                w_flags_next = {w_mul_lo[15], (w_mul_lo == 16'd0), r_status[1:0]};
            end
`endif
            default: ;
        endcase
    end

    assign w_branch = r_v_idex & w_cond_true;
    assign w_baddr  = r_ex_addr + IMEM_AW'({{8{r_ex_imm8[7]}}, r_ex_imm8});

    // Reservation update: the EX clear is applied first so that an ID set
    // of the same register on the same edge wins.
    logic [15:0] w_reserve_next;
    always_comb begin
        w_reserve_next = r_reserve;
        if (r_v_idex && r_ex_wr)
            w_reserve_next[r_ex_rd] = 1'b0;
        if (w_reserve)
            w_reserve_next[w_id_rd] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= '0;
            r_v_ifid     <= 1'b0;
            r_inst_memid <= 16'd0;
            r_origaddr   <= '0;
            for (int i = 0; i < 16; i++)
                r_regs[i] <= 16'd0;
            r_reserve    <= 16'd0;
            r_status     <= 4'd0;
            r_v_idex     <= 1'b0;
            r_ex_opc     <= 4'd0;
            r_ex_rd      <= 4'd0;
            r_ex_a       <= 16'd0;
            r_ex_b       <= 16'd0;
            r_ex_imm8    <= 8'd0;
            r_ex_addr    <= '0;
            r_ex_wr      <= 1'b0;
        end else begin
            // IF: redirect on a taken branch, hold on an ID stall.
            if (w_branch) begin
                r_pc     <= w_baddr;
                r_v_ifid <= 1'b0;
            end else if (!w_stall_idif) begin
                r_pc         <= r_pc + 1'b1;
                r_inst_memid <= w_rom_word;
                r_origaddr   <= r_pc;
                r_v_ifid     <= 1'b1;
            end

            // ID -> EX: a stall or squash sends a bubble.
            r_v_idex <= w_issue;
            if (w_issue) begin
                r_ex_opc  <= w_id_opc;
                r_ex_rd   <= w_id_rd;
                r_ex_a    <= r_regs[w_id_rd];
                r_ex_b    <= r_regs[w_id_rs];
                r_ex_imm8 <= r_inst_memid[7:0];
                r_ex_addr <= r_origaddr;
                r_ex_wr   <= w_id_wr;
            end

            // EX writeback
            if (r_v_idex && r_ex_wr)
                r_regs[r_ex_rd] <= w_rd_data;
            if (r_v_idex)
                r_status <= w_flags_next;

            r_reserve <= w_reserve_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_venus_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_venus_core
//  Purpose  : Self-checking bench for venus_core. Runs a fixed program from
//             the ROM and checks register/status results, issue timing,
//             branch behaviour and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_venus_core;

    function automatic logic [15:0] prog_word(int a);
        case (a)
            0:  return 16'h81FF;  // LDI  r1,#-1
            1:  return 16'h8201;  // LDI  r2,#1
            2:  return 16'h7310;  // MOV  r3,r1
            3:  return 16'h1320;  // ADD  r3,r2
            4:  return 16'h8400;  // LDI  r4,#0
            5:  return 16'h2400;  // ADDX r4,r0
            6:  return 16'h85FF;  // LDI  r5,#-1
            7:  return 16'h957F;  // LDIH r5,#7F
            8:  return 16'h8601;  // LDI  r6,#1
            9:  return 16'h1560;  // ADD  r5,r6
            10: return 16'h3000;  // SUB  r0,r0
            11: return 16'hA2FF;  // BNZ  -1
            12: return 16'hA002;  // B    +2
            13: return 16'h8755;  // LDI  r7,#55 (skipped)
            14: return 16'h8810;  15: return 16'h8911;
            16: return 16'h8A12;  17: return 16'h8B13;
            18: return 16'h8C14;  19: return 16'h8D15;
            20: return 16'h8E16;  21: return 16'h8F17;
            22: return 16'h8803;  23: return 16'h8905;
            24: return 16'h8A80;  25: return 16'h8B0F;
            26: return 16'h8CF0;  27: return 16'h8D33;
            28: return 16'h8E7F;  29: return 16'h8F11;
            30: return 16'h4BC0;  // AND  rb,rc
            31: return 16'h5CA0;  // OR   rc,ra
            32: return 16'h6DE0;  // XOR  rd,re
            33: return 16'hB890;  // MUL  r8,r9
            34: return 16'hBB90;  // MUL  rb,r9
            35: return 16'hA7F0;  // B.never
            36: return 16'hA000;  // B    0 (self loop)
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [4095:0] build_image();
        logic [4095:0] img;
        img = '0;
        for (int i = 0; i < 256; i++)
            img[i*16 +: 16] = prog_word(i);
        return img;
    endfunction

    localparam logic [4095:0] c_PROG = build_image();

    logic clk;
    logic rst;

    venus_core #(
        .IMEM_FILE ("imem.hex"),
        .IMEM_AW   (8),
        .IMEM_INIT (c_PROG)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] idx;  logic [15:0] exp; } reg_vec_t;
    typedef struct packed { logic [7:0] addr; logic [3:0]  exp; } st_vec_t;
    typedef struct packed { logic [7:0] a; logic [7:0] b; logic [7:0] diff; } tm_vec_t;

    int n_chk = 0;
    int n_err = 0;

    int          cyc;
    int          ex_cyc   [256];
    logic [3:0]  st_after [256];
    bit          st_seen  [256];
    bit          prev_v;
    int          prev_addr;
    int          br_run, br_max, br_cnt, br_bad;
    int          br_first_addr, br_first_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_monitor();
        cyc = 0; prev_v = 1'b0; prev_addr = 0;
        br_run = 0; br_max = 0; br_cnt = 0; br_bad = 0;
        br_first_addr = -1; br_first_tgt = -1;
        for (int i = 0; i < 256; i++) begin
            ex_cyc[i] = -1; st_after[i] = 4'hx; st_seen[i] = 1'b0;
        end
    endtask

    task automatic run_cycles(input int n);
        int a;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            a = int'(dut.r_ex_addr);
            if (prev_v && !st_seen[prev_addr]) begin
                st_seen[prev_addr]  = 1'b1;
                st_after[prev_addr] = dut.r_status;
            end
            if (dut.r_v_idex && ex_cyc[a] < 0)
                ex_cyc[a] = cyc;
            prev_v    = dut.r_v_idex;
            prev_addr = a;
            if (dut.w_branch) begin
                br_run++;
                if (br_run > br_max) br_max = br_run;
                if (br_cnt == 0) begin
                    br_first_addr = a;
                    br_first_tgt  = int'(dut.w_baddr);
                end
                br_cnt++;
                if (a != 12 && a != 36) br_bad++;
            end else begin
                br_run = 0;
            end
        end
    endtask

    reg_vec_t reg_tab [16];
    st_vec_t  st_tab  [10];
    tm_vec_t  tm_tab  [11];

    initial begin
        logic [15:0] r8_exp;
        logic [3:0]  mul2_st;
`ifdef VENUS_MUL_EN
        r8_exp  = 16'h000F;
        mul2_st = 4'b0101;
`else
        r8_exp  = 16'h0003;
        mul2_st = 4'b0001;
`endif
        reg_tab[0]  = '{4'h0, 16'h0000}; reg_tab[1]  = '{4'h1, 16'hFFFF};
        reg_tab[2]  = '{4'h2, 16'h0001}; reg_tab[3]  = '{4'h3, 16'h0000};
        reg_tab[4]  = '{4'h4, 16'h0001}; reg_tab[5]  = '{4'h5, 16'h8000};
        reg_tab[6]  = '{4'h6, 16'h0001}; reg_tab[7]  = '{4'h7, 16'h0000};
        reg_tab[8]  = '{4'h8, r8_exp};   reg_tab[9]  = '{4'h9, 16'h0005};
        reg_tab[10] = '{4'hA, 16'hFF80}; reg_tab[11] = '{4'hB, 16'h0000};
        reg_tab[12] = '{4'hC, 16'hFFF0}; reg_tab[13] = '{4'hD, 16'h004C};
        reg_tab[14] = '{4'hE, 16'h007F}; reg_tab[15] = '{4'hF, 16'h0011};

        st_tab[0] = '{8'd3,  4'b0101}; st_tab[1] = '{8'd5,  4'b0000};
        st_tab[2] = '{8'd7,  4'b0000}; st_tab[3] = '{8'd9,  4'b1010};
        st_tab[4] = '{8'd10, 4'b0101}; st_tab[5] = '{8'd11, 4'b0101};
        st_tab[6] = '{8'd30, 4'b0101}; st_tab[7] = '{8'd31, 4'b1001};
        st_tab[8] = '{8'd32, 4'b0001}; st_tab[9] = '{8'd34, mul2_st};

        tm_tab[0]  = '{8'd0,  8'd1,  8'd1};  // independent LDIs
        tm_tab[1]  = '{8'd1,  8'd2,  8'd1};
        tm_tab[2]  = '{8'd2,  8'd3,  8'd2};  // ADD waits on r3
        tm_tab[3]  = '{8'd4,  8'd5,  8'd2};  // ADDX waits on r4
        tm_tab[4]  = '{8'd6,  8'd7,  8'd2};  // LDIH waits on r5
        tm_tab[5]  = '{8'd8,  8'd9,  8'd2};  // ADD waits on r6
        tm_tab[6]  = '{8'd11, 8'd12, 8'd1};  // not-taken branch, no penalty
        tm_tab[7]  = '{8'd12, 8'd14, 8'd3};  // taken branch, two bubbles
        tm_tab[8]  = '{8'd14, 8'd29, 8'd15}; // 16 LDIs, one per cycle
        tm_tab[9]  = '{8'd29, 8'd34, 8'd5};
        tm_tab[10] = '{8'd35, 8'd36, 8'd1};  // never-branch, no penalty

        clear_monitor();

        // Reset
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++)
            chk($sformatf("reset r%0d", i), 32'(dut.r_regs[i]), 32'h0);
        chk("reset status",  32'(dut.r_status),  32'h0);
        chk("reset pc",      32'(dut.r_pc),      32'h0);
        chk("reset v_ifid",  32'(dut.r_v_ifid),  32'h0);
        chk("reset v_idex",  32'(dut.r_v_idex),  32'h0);
        chk("reset reserve", 32'(dut.r_reserve), 32'h0);
        rst = 1'b1;

        // First fetch comes from address 0
        run_cycles(1);
        chk("first fetch valid", 32'(dut.r_v_ifid),     32'h1);
        chk("first fetch addr",  32'(dut.r_origaddr),   32'h0);
        chk("first fetch inst",  32'(dut.r_inst_memid), 32'h81FF);
        chk("first fetch pc",    32'(dut.r_pc),         32'h1);

        run_cycles(89);

        foreach (reg_tab[i])
            chk($sformatf("final r%0d", reg_tab[i].idx),
                32'(dut.r_regs[reg_tab[i].idx]), 32'(reg_tab[i].exp));
        foreach (st_tab[i])
            chk($sformatf("status after @%0d", st_tab[i].addr),
                32'(st_after[st_tab[i].addr]), 32'(st_tab[i].exp));
        foreach (tm_tab[i])
            chk($sformatf("issue gap @%0d->@%0d", tm_tab[i].a, tm_tab[i].b),
                32'(ex_cyc[tm_tab[i].b] - ex_cyc[tm_tab[i].a]), 32'(tm_tab[i].diff));

        chk("skipped inst never in EX", 32'(ex_cyc[13]), 32'hFFFF_FFFF);
        chk("first branch addr",  32'(br_first_addr), 32'd12);
        chk("first branch tgt",   32'(br_first_tgt),  32'd14);
        chk("branch pulse width", 32'(br_max),        32'd1);
        chk("unexpected branches", 32'(br_bad),       32'd0);
        chk("reservations idle",  32'(dut.r_reserve), 32'h0);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset r1",      32'(dut.r_regs[1]), 32'h0);
        chk("midreset r5",      32'(dut.r_regs[5]), 32'h0);
        chk("midreset status",  32'(dut.r_status),  32'h0);
        chk("midreset pc",      32'(dut.r_pc),      32'h0);
        chk("midreset v_idex",  32'(dut.r_v_idex),  32'h0);
        @(posedge clk);
        #1;
        chk("held reset r1", 32'(dut.r_regs[1]), 32'h0);
        chk("held reset pc", 32'(dut.r_pc),      32'h0);
        @(negedge clk);
        rst = 1'b1;
        clear_monitor();
        run_cycles(1);
        chk("refetch addr", 32'(dut.r_origaddr), 32'h0);
        run_cycles(2);
        chk("restart r1", 32'(dut.r_regs[1]), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
